// File: rtl/hilo_muldiv.sv
// hilo_muldiv
//   HI/LO register pair with a multi-cycle multiply/divide engine for the
//   execute stage. MULT/MULTU write the full product in one extra cycle.
//   MADD*/MSUB* accumulate the product into {HI,LO}. DIV/DIVU run a
//   restoring radix-2 divider (DW cycles) and then a sign-fix cycle.
//   MTHI/MTLO write directly and are bypassed onto rdata in the same cycle.
//
// Ports
//   clk     clock
//   resetn  synchronous active-low reset
//   start   launch op (ignored while busy or while cancel=1)
//   op      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,6 MSUB,7 MSUBU,
//           8 MTHI,9 MTLO, others no-op
//   src_a   multiplicand / dividend / MT data
//   src_b   multiplier / divisor
//   cancel  flush: abort an in-flight op, HI/LO untouched
//   ren     [1] read HI, [0] read LO
//   busy    engine occupied (registered)
//   done    one-cycle pulse after HI/LO were written by mul/div/acc
//   rdata   combinational read data
module hilo_muldiv #(
  parameter int DW   = 32,
  parameter int CNTW = 6
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          cancel,
  input  logic [1:0]    ren,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DW-1:0]     r_hi, r_lo;
  logic [3:0]        r_op;
  logic [DW-1:0]     r_a;       // multiplicand, or dividend shifting into quotient
  logic [DW-1:0]     r_b;       // multiplier, or divisor magnitude
  logic [DW-1:0]     r_rem;
  logic [DW-1:0]     r_src_a;   // raw dividend, returned in HI on divide-by-zero
  logic [CNTW-1:0]   r_cnt;
  logic              r_qneg, r_rneg, r_dz;
  logic              r_busy, r_done;

  logic              w_accept, w_launch_mul, w_launch_div;
  logic              w_mt_hi, w_mt_lo, w_commit;
  logic [2*DW-1:0]   w_a_ext, w_b_ext, w_prod, w_hilo, w_mul_result;
  logic [DW:0]       w_shift, w_diff;
  logic              w_qbit;
  logic              w_neg_a, w_neg_b;

  // ---------------- next-state / control ----------------
  always_comb begin
    w_state_next = r_state;
    w_launch_mul = 1'b0;
    w_launch_div = 1'b0;
    w_mt_hi      = 1'b0;
    w_mt_lo      = 1'b0;
    w_accept     = (r_state == S_IDLE) && start && !cancel;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
              w_launch_mul = 1'b1;
              w_state_next = S_MUL;
            end
            4'd2, 4'd3: begin
              w_launch_div = 1'b1;
              w_state_next = S_DIV;
            end
            4'd8:    w_mt_hi = 1'b1;
            4'd9:    w_mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL: w_state_next = S_IDLE;
      S_DIV: begin
        if (cancel)
          w_state_next = S_IDLE;
        else if (r_cnt == CNTW'(DW - 1))
          w_state_next = S_FIX;
      end
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // A cancel in the completion cycle suppresses the HI/LO write.
    w_commit = !cancel && ((r_state == S_MUL) || (r_state == S_FIX));
  end

  // ---------------- multiply datapath ----------------
  // Sign/zero-extend to 2*DW so that one truncated multiply covers both
  // the signed and unsigned product.
  always_comb begin
    if (!r_op[0]) begin
      w_a_ext = {{DW{r_a[DW-1]}}, r_a};
      w_b_ext = {{DW{r_b[DW-1]}}, r_b};
    end else begin
      w_a_ext = {{DW{1'b0}}, r_a};
      w_b_ext = {{DW{1'b0}}, r_b};
    end
    w_prod = w_a_ext * w_b_ext;
    w_hilo = {r_hi, r_lo};
    case (r_op[2:1])
      2'b10:   w_mul_result = w_hilo + w_prod;
      2'b11:   w_mul_result = w_hilo - w_prod;
      default: w_mul_result = w_prod;
    endcase
  end

  // ---------------- divide datapath ----------------
  always_comb begin
    w_neg_a = !op[0] && src_a[DW-1];
    w_neg_b = !op[0] && src_b[DW-1];
    w_shift = {r_rem, r_a[DW-1]};
    w_diff  = w_shift - {1'b0, r_b};
    w_qbit  = !w_diff[DW];
  end

  // ---------------- state and registers ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_src_a <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_commit;

      if (w_mt_hi) r_hi <= src_a;
      if (w_mt_lo) r_lo <= src_a;

      if (w_launch_mul) begin
        r_op <= op;
        r_a  <= src_a;
        r_b  <= src_b;
      end

      if (w_launch_div) begin
        r_op    <= op;
        r_a     <= w_neg_a ? -src_a : src_a;
        r_b     <= w_neg_b ? -src_b : src_b;
        r_rem   <= '0;
        r_cnt   <= '0;
        r_qneg  <= w_neg_a ^ w_neg_b;
        r_rneg  <= w_neg_a;
        r_dz    <= (src_b == '0);
        r_src_a <= src_a;
      end

      if (r_state == S_DIV) begin
        r_rem <= w_qbit ? w_diff[DW-1:0] : w_shift[DW-1:0];
        r_a   <= {r_a[DW-2:0], w_qbit};
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_commit && (r_state == S_MUL))
        {r_hi, r_lo} <= w_mul_result;

      if (w_commit && (r_state == S_FIX)) begin
        if (r_dz) begin
          r_lo <= '1;
          r_hi <= r_src_a;
        end else begin
          // The magnitude of the most negative dividend wraps back to itself,
          // which yields the required quotient/remainder for the overflow case.
          r_lo <= r_qneg ? -r_a : r_a;
          r_hi <= r_rneg ? -r_rem : r_rem;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign busy = r_busy;
  assign done = r_done;

  always_comb begin
    rdata = '0;
    if (ren[1])
      rdata = w_mt_hi ? src_a : r_hi;
    else if (ren[0])
      rdata = w_mt_lo ? src_a : r_lo;
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic [1:0]  ren;
  logic        busy, done;
  logic [31:0] rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] model_hilo;

  always #5 clk = ~clk;

  hilo_muldiv #(.DW(32), .CNTW(6)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel), .ren(ren),
    .busy(busy), .done(done), .rdata(rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    int          ia, ib;
    longint      la, lb;
    logic [63:0] p, q, r;
    ia = a; ib = b; la = ia; lb = ib;
    if (o[0]) p = {32'b0, a} * {32'b0, b};
    else      p = la * lb;
    case (o)
      4'd0, 4'd1: model = p;
      4'd4, 4'd5: model = hilo + p;
      4'd6, 4'd7: model = hilo - p;
      4'd2, 4'd3: begin
        if (b == 32'd0) model = {a, 32'hFFFFFFFF};
        else begin
          if (o[0]) begin q = {32'b0, a} / {32'b0, b}; r = {32'b0, a} % {32'b0, b}; end
          else      begin q = la / lb; r = la % lb; end
          model = {r[31:0], q[31:0]};
        end
      end
      4'd8:    model = {a, hilo[31:0]};
      4'd9:    model = {hilo[63:32], a};
      default: model = hilo;
    endcase
  endfunction

  task automatic read_hilo(output logic [63:0] v);
    ren = 2'b10; #1; v[63:32] = rdata;
    ren = 2'b01; #1; v[31:0]  = rdata;
    ren = 2'b00;
  endtask

  // Issue one op at a negedge; for mul/div ops wait for done and check
  // busy length and the scoreboard entry. inject=1 pokes a start mid-op.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int          cycles, guard, exp_cycles;
    logic [63:0] got, exp;
    bit          is_md;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    is_md = (o <= 4'd7);
    exp_cycles = (o == 4'd2 || o == 4'd3) ? 33 : 1;
    if (is_md) sb_q.push_back(model(o, a, b, model_hilo));
    model_hilo = model(o, a, b, model_hilo);
    @(negedge clk);
    start = 1'b0;
    if (is_md) begin
      cycles = 0; guard = 0;
      while (!done && guard < 200) begin
        if (busy) cycles++;
        start = inject && (cycles == 5);
        if (start) begin op = 4'd0; src_a = 32'h1234; src_b = 32'h5; end
        @(negedge clk);
        guard++;
      end
      start = 1'b0;
      check_eq({tag, "_done_seen"}, {63'b0, done}, 64'd1);
      check_eq({tag, "_busy_cycles"}, cycles, exp_cycles);
      exp = sb_q.pop_front();
      read_hilo(got);
      check_eq({tag, "_hilo"}, got, exp);
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
      $display("[TB] %s op=%0d a=%h b=%h busy=%0d hilo=%h", tag, o, a, b, cycles, got);
    end else begin
      read_hilo(got);
      check_eq({tag, "_hilo"}, got, model_hilo);
      $display("[TB] %s op=%0d a=%h hilo=%h", tag, o, a, got);
    end
  endtask

  initial begin
    logic [63:0] v;
    int          n, dones;
    resetn = 1'b0; start = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    cancel = 1'b0; ren = 2'b00;
    model_hilo = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check_eq("rst_busy", {63'b0, busy}, 64'd0);
    check_eq("rst_done", {63'b0, done}, 64'd0);
    read_hilo(v);
    check_eq("rst_hilo", v, 64'd0);
    $display("[TB] reset hilo=%h", v);

    run_op("mult",  4'd0, 32'hFFFFFFFF, 32'h2, 1'b0);
    check_eq("mult_abs", model_hilo, 64'hFFFFFFFF_FFFFFFFE);
    run_op("multu", 4'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
    check_eq("multu_abs", model_hilo, 64'h00000001_FFFFFFFE);
    run_op("div",   4'd2, 32'hFFFFFFF9, 32'h2, 1'b1);
    check_eq("div_abs", model_hilo, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu",  4'd3, 32'hFFFFFFF9, 32'h2, 1'b0);
    check_eq("divu_abs", model_hilo, 64'h00000001_7FFFFFFC);
    run_op("divu0", 4'd3, 32'h12345678, 32'h0, 1'b0);
    check_eq("divu0_abs", model_hilo, 64'h12345678_FFFFFFFF);
    run_op("divov", 4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check_eq("divov_abs", model_hilo, 64'h00000000_80000000);

    run_op("mthi",  4'd8, 32'h0, 32'h0, 1'b0);
    run_op("mtlo",  4'd9, 32'hFFFFFFFF, 32'h0, 1'b0);
    run_op("maddu", 4'd5, 32'h1, 32'h1, 1'b0);
    check_eq("maddu_abs", model_hilo, 64'h00000001_00000000);
    run_op("msub",  4'd6, 32'h1, 32'h1, 1'b0);
    check_eq("msub_abs", model_hilo, 64'h00000000_FFFFFFFF);

    // Cancel on the 10th busy cycle of a DIV.
    run_op("mthi_a5", 4'd8, 32'hA5A5A5A5, 32'h0, 1'b0);
    run_op("mtlo_a5", 4'd9, 32'hA5A5A5A5, 32'h0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 4'd2; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    check_eq("cancel_busy_before", {63'b0, busy}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_eq("cancel_busy", {63'b0, busy}, 64'd0);
    check_eq("cancel_done", {63'b0, done}, 64'd0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done || busy) dones++; end
    check_eq("cancel_quiet", dones, 0);
    read_hilo(v);
    check_eq("cancel_hilo", v, 64'hA5A5A5A5_A5A5A5A5);
    $display("[TB] cancel div hilo=%h", v);

    // Start with cancel=1 launches nothing (MTLO included).
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 4'd3; src_a = 32'd9; src_b = 32'd3;
    @(negedge clk);
    op = 4'd9; src_a = 32'h0;
    ren = 2'b01; #1;
    check_eq("cancel_mtlo_nobypass", rdata, 32'hA5A5A5A5);
    ren = 2'b00;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    dones = 0;
    repeat (40) begin @(negedge clk); if (done || busy) dones++; end
    check_eq("cancel_start_quiet", dones, 0);
    read_hilo(v);
    check_eq("cancel_start_hilo", v, 64'hA5A5A5A5_A5A5A5A5);
    $display("[TB] start+cancel hilo=%h", v);

    // MTLO bypass.
    @(negedge clk);
    start = 1'b1; op = 4'd9; src_a = 32'hDEADBEEF; ren = 2'b01;
    #1;
    check_eq("bypass_lo", rdata, 32'hDEADBEEF);
    ren = 2'b10; #1;
    check_eq("bypass_hi_none", rdata, 32'hA5A5A5A5);
    model_hilo[31:0] = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; ren = 2'b01; #1;
    check_eq("bypass_lo_after", rdata, 32'hDEADBEEF);
    ren = 2'b00;
    $display("[TB] mtlo bypass lo=%h", rdata);

    // Reset mid-DIV.
    @(negedge clk);
    start = 1'b1; op = 4'd2; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    model_hilo = '0;
    check_eq("rstmid_busy", {63'b0, busy}, 64'd0);
    read_hilo(v);
    check_eq("rstmid_hilo", v, 64'd0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    check_eq("rstmid_nodone", dones, 0);
    $display("[TB] reset mid-div hilo=%h", v);

    // Random mul/div/accumulate traffic through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2) ? ($urandom & 32'hFF) : $urandom);
      run_op("rand", ro, ra, rb, 1'b0);
    end

    check_eq("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Parametrised HI/LO register pair with an integrated multi-cycle multiply/divide engine for the execute stage. It supports signed and unsigned MULT/DIV, MADD/MSUB accumulate into {HI,LO}, and MTHI/MTLO with a same-cycle bypass. An exception/flush input aborts in-flight operations without touching HI/LO. The pipeline stalls on `busy`; reads go through `rdata`.

Parameters:
DW, 32, data width of HI, LO and operands (≥4, even)
CNTW, 6, iteration-counter width; must satisfy 2^CNTW > DW

Ports:
clk        in   1      clock
resetn     in   1      synchronous, active-low reset
start      in   1      launch op (ignored while busy or cancel=1)
op         in   4      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; others = no-op
src_a      in   DW     multiplicand / dividend / MT data
src_b      in   DW     multiplier / divisor
cancel     in   1      exception flush: abort in-flight op
ren        in   2      [1] read HI, [0] read LO (one-hot or zero)
busy       out  1      engine occupied
done       out  1      one-cycle pulse: HI/LO updated by mul/div/acc
rdata      out  DW     read data

Behaviour:
- Reset (resetn=0 at posedge): HI=LO=0, FSM=IDLE, busy=0, done=0, counter=0, all internal operand registers 0. Reset mid-operation abandons the operation immediately.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start + !cancel + op∈{0,1,4..7}: at edge E0 latch operands, go to MUL. busy=1 during the cycle after E0.
  - At E1, write the product (signed for 0/4/6, unsigned for 1/5/7; 2·DW bits) as follows:
    - MULT/MULTU: {HI,LO} = product.
    - MADD*: {HI,LO} = {HI,LO} + product, mod 2^(2DW).
    - MSUB*: {HI,LO} = {HI,LO} − product, mod 2^(2DW).
  - After E1: IDLE, busy=0, done=1 for exactly one cycle.
- IDLE + start + !cancel + op∈{2,3}: at E0 latch |a|,|b| (signed) or a,b (unsigned) and the result signs. Go to DIV with counter=0.
  - DIV is restoring radix-2, one quotient bit per cycle, DW cycles. Then FIX for one cycle: apply signs.
  - At E(DW+1): LO=quotient, HI=remainder, back to IDLE, done pulses.
  - busy is high for exactly DW+1 cycles.
  - Signed results: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor 0: LO = all ones, HI = src_a; same latency.
  - Signed overflow (−2^(DW−1) / −1): LO = −2^(DW−1), HI = 0.
- MTHI/MTLO (op 8/9) with start in IDLE: write HI/LO from src_a at E0. No busy, no done.
- Start while busy: ignored. Undefined op with start: no-op.
- cancel=1 in any non-IDLE state: at next edge go to IDLE, busy=0, done=0, HI/LO unchanged. cancel with start in the same cycle: start dropped (MTHI/MTLO included).
- cancel has no effect in IDLE. Cancel in the completion cycle (MUL or FIX): suppress the write.
- rdata (combinational):
  - ren[1]: HI; ren[0]: LO; ren=0: 0.
  - Bypass: if an accepted MTHI (MTLO) is presented this cycle, return src_a instead of HI (LO).
  - No bypass for mul/div results. While busy, rdata shows the old HI/LO; the pipeline must stall on busy.
- done and busy are registered. done never coincides with busy=1 of the same op.

Test Plan:
- DW=32, MULT a=0xFFFFFFFF, b=0x00000002 -> busy 1 cycle, then done; HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 -> busy exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- DIVU a=0x12345678, b=0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1×1 -> HI=0x00000001, LO=0. Then MSUB 1×1 -> HI=0, LO=0xFFFFFFFF.
- HI=LO=0xA5A5A5A5, start DIV, cancel on the 10th busy cycle -> busy=0 next cycle, no done, HI/LO unchanged. Start with cancel=1 -> nothing launched.
- MTLO src_a=0xDEADBEEF with ren=01 in the same cycle -> rdata=0xDEADBEEF combinationally, LO=0xDEADBEEF after the edge. Reset asserted mid-DIV -> HI=LO=0, busy=0.
